mat_vect_mult_stream: RTL and testbench
=======================================

MAT_VECT_MULT_STREAM -- requirements
Module: mat_vect_mult_stream

Interface
REQ-001 SHALL have parameter M, default 3, number of matrix rows / result elements.
REQ-002 SHALL have parameter N, default 3, number of matrix columns / vector elements (N>=1).
REQ-003 SHALL have parameter DW, default 8, element width.
REQ-004 SHALL have parameter SIGNED, default 0; 0 = unsigned, 1 = two's-complement operands and results.
REQ-005 SHALL define ACCW = 2*DW + $clog2(N) and RW = max(1,$clog2(M)).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 clear  input  1  synchronous flush of the current job.
REQ-009 in_valid  input  1  column beat valid.
REQ-010 in_ready  output  1  column beat accepted when in_valid && in_ready.
REQ-011 in_mat_col  input  [DW-1:0] x M (unpacked [0:M-1])  column j of matrix A, element i = A[i][j].
REQ-012 in_vect  input  DW  vector element b[j] for the same beat.
REQ-013 out_valid  output  1  result element valid.
REQ-014 out_ready  input  1  result element consumed when out_valid && out_ready.
REQ-015 out_data  output  ACCW  result element y[i] = sum_j A[i][j]*b[j].
REQ-016 out_row  output  RW  row index i of out_data.
REQ-017 out_last  output  1  high with row M-1.
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, DRAIN.
REQ-020 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DRAIN.
REQ-021 IDLE: accepted beat SHALL load every accumulator with its product (no add), set column count to 1, go to ACCUM (or DRAIN if N==1).
REQ-022 ACCUM: each accepted beat SHALL add A[i][j]*b[j] into accumulator i and increment column count; accepting beat N SHALL transition to DRAIN next cycle.
REQ-023 Cycles with in_valid=0 SHALL leave accumulators and count unchanged.
REQ-024 Products and sums SHALL be sign- or zero-extended to ACCW per SIGNED; no overflow is possible at ACCW and no saturation SHALL be applied.
REQ-025 DRAIN: out_valid=1, out_data = accumulator[row], out_row = row, starting at row 0 on first DRAIN cycle.
REQ-026 out_data/out_row/out_last SHALL hold stable while out_valid && !out_ready.
REQ-027 Each output handshake SHALL advance row; handshake on row M-1 (out_last=1) SHALL return to IDLE, in_ready=1 the following cycle.
REQ-028 Throughput: one column beat per cycle in ACCUM, one result per cycle in DRAIN with out_ready held high; job latency = N accept cycles + M drain cycles.
REQ-029 clear SHALL return FSM to IDLE next cycle from any state, discarding partial results; clear overrides a coincident input or output handshake, which SHALL not take effect.
REQ-030 out_valid SHALL be 0 outside DRAIN.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, column count=0, row=0, accumulators=0; outputs out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, in_ready=1 (while rst_n low: in_ready=0).
REQ-032 Reset mid-ACCUM or mid-DRAIN SHALL discard the job; first beat after release starts a new job.

Structure
REQ-033 Package mvm_pkg SHALL hold the state enum typedef and the ACCW width function.
REQ-034 One sub-module mac_lane (parameters DW, ACCW, SIGNED; ports clk, rst_n, load, en, a, b, acc) SHALL be instantiated M times via generate.
REQ-035 Output row select SHALL be a registered mux over the M accumulators; no combinational path from in_* to out_*.

Verification
REQ-036 M=3,N=3,DW=8,SIGNED=0: A=[[1,2,3],[4,5,6],[7,8,9]], b=[1,1,1], out_ready=1 -> 6,15,24 rows 0..2, out_last on 24.
REQ-037 SIGNED=1, all A=-128, b=-128, N=3 -> each y=49152; A row0=[127,-1,0], b=[-1,2,5] -> y0=-129.
REQ-038 in_valid toggled every other cycle and out_ready low 3 cycles on row 1 -> identical results, out_data held stable at 15.
REQ-039 rst_n pulsed low after 2 beats, then full job b=[2,0,1] on case-1 A -> 5,14,23, no stale data.
REQ-040 clear asserted coincident with beat 3 and with row-1 handshake -> FSM IDLE, beat/handshake ignored, next job correct.
REQ-041 Back-to-back jobs with in_valid held high -> in_ready low exactly M cycles between jobs, second job unaffected by first.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Accumulator width: full product plus enough headroom for N additions.
    function automatic int accw_f(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Row index width, never narrower than one bit.
    function automatic int rw_f(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: holds the running dot product for a single row.
module mac_lane #(
    parameter int DW     = 8,
    parameter int ACCW   = 18,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] a_s;
    logic signed [2*DW-1:0] b_s;
    logic signed [2*DW-1:0] prod_s;
    logic        [2*DW-1:0] prod_u;
    logic        [ACCW-1:0] ext_s;
    logic        [ACCW-1:0] ext_u;
    logic        [ACCW-1:0] prod_ext;
    logic        [ACCW-1:0] acc_d;
    logic        [ACCW-1:0] acc_q;

    // Operands are widened to the full product width before multiplying so the
    // product is exact in both number systems.
    assign a_s    = (2*DW)'($signed(a));
    assign b_s    = (2*DW)'($signed(b));
    assign prod_s = a_s * b_s;
    assign prod_u = (2*DW)'(a) * (2*DW)'(b);

    // The signed cast sign-extends, the unsigned one zero-extends.
    assign ext_s    = ACCW'(prod_s);
    assign ext_u    = ACCW'(prod_u);
    assign prod_ext = (SIGNED != 0) ? ext_s : ext_u;

    // The first beat of a job overwrites stale contents instead of adding.
    assign acc_d = load ? prod_ext :
                   en   ? acc_q + prod_ext :
                          acc_q;

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mat_vect_mult_stream.sv
// Streaming y = A*b: one matrix column plus one vector element per beat,
// then the M result elements are drained one per handshake.
module mat_vect_mult_stream
    import mvm_pkg::*;
#(
    parameter  int M      = 3,
    parameter  int N      = 3,
    parameter  int DW     = 8,
    parameter  int SIGNED = 0,
    localparam int ACCW   = accw_f(DW, N),
    localparam int RW     = rw_f(M)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_mat_col [0:M-1],
    input  logic [DW-1:0]   in_vect,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic [RW-1:0]   out_row,
    output logic            out_last,
    output logic            busy
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(N - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);

    state_e          state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            lane_load;
    logic            lane_en;
    logic [ACCW-1:0] acc_w [0:M-1];

    // clear wins over a coincident beat so a flushed job never touches the lanes.
    assign lane_load = (state_q == IDLE)  && in_valid && !clear;
    assign lane_en   = (state_q == ACCUM) && in_valid && !clear;

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_lane
            mac_lane #(
                .DW     (DW),
                .ACCW   (ACCW),
                .SIGNED (SIGNED)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (lane_load),
                .en    (lane_en),
                .a     (in_mat_col[gi]),
                .b     (in_vect),
                .acc   (acc_w[gi])
            );
        end
    endgenerate

    // Job sequencing FSM: column counting, drain row pointer and output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        col_q <= CW'(1);
                        if (N == 1) begin
                            state_q     <= DRAIN;
                            row_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (M == 1);
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        col_q <= col_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            state_q     <= DRAIN;
                            row_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (LAST_ROW == '0);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_q == LAST_ROW) begin
                            state_q     <= IDLE;
                            col_q       <= '0;
                            row_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            row_q      <= row_q + 1'b1;
                            out_last_q <= ((row_q + 1'b1) == LAST_ROW);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Accumulators are frozen in DRAIN, so selecting with the registered row
    // pointer keeps out_data stable under backpressure and isolated from in_*.
    assign out_data  = acc_w[row_q];
    assign out_row   = row_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign in_ready  = rst_n && (state_q != DRAIN);

endmodule

// File: tb/tb_mat_vect_mult_stream.sv
// Bench for mat_vect_mult_stream: an unsigned and a signed instance share all
// inputs; a scoreboard queue holds per-row results for both number systems.
module tb_mat_vect_mult_stream;

    localparam int M    = 3;
    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int ACCW = 2 * DW + $clog2(N);
    localparam int RW   = 2;

    typedef logic [DW-1:0] mat_t [0:M-1][0:N-1];
    typedef logic [DW-1:0] vec_t [0:N-1];
    typedef struct {
        logic [ACCW-1:0] du;
        logic [ACCW-1:0] ds;
        logic [RW-1:0]   row;
        logic            last;
    } exp_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            clear;
    logic            in_valid;
    logic            out_ready;
    logic [DW-1:0]   in_mat_col [0:M-1];
    logic [DW-1:0]   in_vect;

    logic            in_ready_u, out_valid_u, out_last_u, busy_u;
    logic [ACCW-1:0] out_data_u;
    logic [RW-1:0]   out_row_u;
    logic            in_ready_s, out_valid_s, out_last_s, busy_s;
    logic [ACCW-1:0] out_data_s;
    logic [RW-1:0]   out_row_s;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mat_t A1 = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
    mat_t A2 = '{'{8'd10, 8'd0, 8'd1}, '{8'd200, 8'd3, 8'd7}, '{8'd255, 8'd255, 8'd255}};

    always #5 clk = ~clk;

    mat_vect_mult_stream #(.M(M), .N(N), .DW(DW), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_mat_col(in_mat_col), .in_vect(in_vect), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_row(out_row_u), .out_last(out_last_u), .busy(busy_u)
    );

    mat_vect_mult_stream #(.M(M), .N(N), .DW(DW), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_mat_col(in_mat_col), .in_vect(in_vect), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_row(out_row_s), .out_last(out_last_s), .busy(busy_s)
    );

    // Reference model: dot products in int, truncated to the accumulator width.
    function automatic void push_expected(input mat_t a, input vec_t b);
        exp_t e;
        int   su;
        int   ss;
        for (int i = 0; i < M; i++) begin
            su = 0;
            ss = 0;
            for (int j = 0; j < N; j++) begin
                su += int'(a[i][j]) * int'(b[j]);
                ss += int'($signed(a[i][j])) * int'($signed(b[j]));
            end
            e.du   = ACCW'(su);
            e.ds   = ACCW'(ss);
            e.row  = RW'(i);
            e.last = (i == M - 1);
            sb.push_back(e);
        end
    endfunction

    // Scoreboard consumer: each result handshake is matched in order
    always @(negedge clk) begin
        if (rst_n && out_valid_u && out_ready && !clear) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: row=%0d data=%0d while no result pending", out_row_u, out_data_u);
            end else begin
                mon_e = sb.pop_front();
                if (out_data_u !== mon_e.du || out_row_u !== mon_e.row || out_last_u !== mon_e.last) begin
                    errors++;
                    $display("FAIL result_unsigned: data=%0d row=%0d last=%0b, expected data=%0d row=%0d last=%0b",
                             out_data_u, out_row_u, out_last_u, mon_e.du, mon_e.row, mon_e.last);
                end
                checks++;
                if (out_valid_s !== 1'b1 || out_data_s !== mon_e.ds || out_row_s !== mon_e.row || out_last_s !== mon_e.last) begin
                    errors++;
                    $display("FAIL result_signed: valid=%0b data=%0d row=%0d last=%0b, expected valid=1 data=%0d row=%0d last=%0b",
                             out_valid_s, out_data_s, out_row_s, out_last_s, mon_e.ds, mon_e.row, mon_e.last);
                end
            end
        end
    end

    // Stimulus: present N beats (optionally with an idle cycle after each) and
    // queue the expected results once the final beat is accepted.
    task automatic feed_job(input mat_t a, input vec_t b, input bit toggle);
        int j     = 0;
        int guard = 0;
        bit skip  = 1'b0;
        while (j < N && guard < 50) begin
            if (skip) begin
                in_valid = 1'b0;
                skip     = 1'b0;
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < M; i++) in_mat_col[i] = a[i][j];
                in_vect = b[j];
                skip    = toggle;
            end
            @(negedge clk);
            if (in_valid && in_ready_u) j++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (j != N) begin
            errors++;
            $display("FAIL feed_timeout: accepted=%0d beats, expected=%0d", j, N);
        end else begin
            push_expected(a, b);
        end
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d results, expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vect   = '0;
        for (int i = 0; i < M; i++) in_mat_col[i] = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready_u !== 1'b0 || in_ready_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got=%0b/%0b, expected=0", in_ready_u, in_ready_s);
        end
        checks++;
        if (out_valid_u !== 1'b0 || out_valid_s !== 1'b0 || busy_u !== 1'b0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%0b/%0b busy=%0b/%0b, expected=0", out_valid_u, out_valid_s, busy_u, busy_s);
        end
        checks++;
        if (out_data_u !== '0 || out_data_s !== '0 || out_row_u !== '0 || out_last_u !== 1'b0 || out_last_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data=%0d/%0d row=%0d last=%0b, expected=0", out_data_u, out_data_s, out_row_u, out_last_u);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready_u !== 1'b1 || in_ready_s !== 1'b1 || busy_u !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: in_ready=%0b/%0b busy=%0b, expected in_ready=1 busy=0", in_ready_u, in_ready_s, busy_u);
        end
    endtask

    task automatic test_basic();
        vec_t b;
        b = '{8'd1, 8'd1, 8'd1};
        out_ready = 1'b1;
        feed_job(A1, b, 1'b0);
        @(negedge clk);
        checks++;
        if (busy_u !== 1'b1 || in_ready_u !== 1'b0 || out_valid_u !== 1'b1 || out_data_u !== 18'd6) begin
            errors++;
            $display("FAIL drain_entry: busy=%0b in_ready=%0b valid=%0b data=%0d, expected 1 0 1 6", busy_u, in_ready_u, out_valid_u, out_data_u);
        end
        @(posedge clk); #1;
        drain();
        @(negedge clk);
        checks++;
        if (busy_u !== 1'b0 || in_ready_u !== 1'b1 || out_valid_u !== 1'b0) begin
            errors++;
            $display("FAIL job_done_idle: busy=%0b in_ready=%0b valid=%0b, expected 0 1 0", busy_u, in_ready_u, out_valid_u);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        mat_t a;
        vec_t b;
        logic [ACCW-1:0] neg129;
        neg129 = ACCW'(-129);
        for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) a[i][j] = 8'h80;
        b = '{8'h80, 8'h80, 8'h80};
        out_ready = 1'b1;
        feed_job(a, b, 1'b0);
        @(negedge clk);
        checks++;
        if (out_data_s !== 18'd49152 || out_data_u !== 18'd49152) begin
            errors++;
            $display("FAIL min_operands: data=%0d/%0d, expected=49152", out_data_u, out_data_s);
        end
        @(posedge clk); #1;
        drain();
        a = '{'{8'h7F, 8'hFF, 8'h00}, '{8'h01, 8'h02, 8'h03}, '{8'hFB, 8'h04, 8'hFD}};
        b = '{8'hFF, 8'h02, 8'h05};
        out_ready = 1'b0;
        feed_job(a, b, 1'b0);
        @(negedge clk);
        checks++;
        if (out_data_s !== neg129) begin
            errors++;
            $display("FAIL signed_negative: data=%0d, expected=%0d", out_data_s, neg129);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_stall();
        vec_t b;
        b = '{8'd1, 8'd1, 8'd1};
        out_ready = 1'b0;
        feed_job(A1, b, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid_u !== 1'b1 || out_row_u !== 2'd1 || out_data_u !== 18'd15 || out_last_u !== 1'b0 || out_data_s !== 18'd15) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b row=%0d data=%0d/%0d last=%0b, expected 1 1 15 0",
                         out_valid_u, out_row_u, out_data_u, out_data_s, out_last_u);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        vec_t b;
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            in_valid = 1'b1;
            for (int i = 0; i < M; i++) in_mat_col[i] = A1[i][j];
            in_vect = 8'd1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_u !== 1'b0 || busy_s !== 1'b0 || in_ready_u !== 1'b0 || out_valid_u !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_job: busy=%0b/%0b in_ready=%0b valid=%0b, expected 0", busy_u, busy_s, in_ready_u, out_valid_u);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        b = '{8'd2, 8'd0, 8'd1};
        feed_job(A1, b, 1'b0);
        drain();
    endtask

    task automatic test_clear();
        vec_t b;
        out_ready = 1'b1;
        for (int j = 0; j < N; j++) begin
            in_valid = 1'b1;
            for (int i = 0; i < M; i++) in_mat_col[i] = A1[i][j];
            in_vect = 8'd1;
            clear   = (j == N - 1);
            @(posedge clk); #1;
        end
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_u !== 1'b0 || out_valid_u !== 1'b0 || in_ready_u !== 1'b1 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL clear_on_beat: busy=%0b/%0b valid=%0b in_ready=%0b, expected busy=0 valid=0 in_ready=1",
                     busy_u, busy_s, out_valid_u, in_ready_u);
        end
        @(posedge clk); #1;
        b = '{8'd1, 8'd2, 8'd3};
        feed_job(A1, b, 1'b0);
        drain();
        b = '{8'd1, 8'd1, 8'd1};
        feed_job(A1, b, 1'b0);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_u !== 1'b0 || out_valid_u !== 1'b0 || out_valid_s !== 1'b0 || out_row_u !== 2'd0) begin
            errors++;
            $display("FAIL clear_on_handshake: busy=%0b valid=%0b/%0b row=%0d, expected 0 0 0 0",
                     busy_u, out_valid_u, out_valid_s, out_row_u);
        end
        checks++;
        if (sb.size() != 2) begin
            errors++;
            $display("FAIL clear_discard: pending=%0d results, expected=2", sb.size());
        end
        sb.delete();
        @(posedge clk); #1;
        b = '{8'd3, 8'd1, 8'd0};
        feed_job(A1, b, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        vec_t b1;
        vec_t b2;
        int   k     = 0;
        int   low   = 0;
        int   guard = 0;
        b1 = '{8'd1, 8'd1, 8'd1};
        b2 = '{8'd2, 8'd3, 8'd4};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (k < 2 * N && guard < 100) begin
            for (int i = 0; i < M; i++) in_mat_col[i] = (k < N) ? A1[i][k % N] : A2[i][k % N];
            in_vect = (k < N) ? b1[k % N] : b2[k % N];
            @(negedge clk);
            if (in_ready_u) begin
                k++;
                if (k == N) push_expected(A1, b1);
                if (k == 2 * N) push_expected(A2, b2);
            end else if (k == N) begin
                low++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (k != 2 * N || low != M) begin
            errors++;
            $display("FAIL back_to_back_gap: beats=%0d ready_low=%0d, expected beats=%0d ready_low=%0d", k, low, 2 * N, M);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_stall();
        test_reset_mid();
        test_clear();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
